// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass and a per-register
// busy scoreboard used by decode for hazard detection.
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wb0_en,
   input  logic [ADDR_W-1:0]          wb0_idx,
   input  logic [DATA_W-1:0]          wb0_data,
   input  logic                       wb1_en,
   input  logic [ADDR_W-1:0]          wb1_idx,
   input  logic [DATA_W-1:0]          wb1_data,
   input  logic                       sb_set_en,
   input  logic [ADDR_W-1:0]          sb_set_idx,
   input  logic                       sb_flush,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_idx,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_RD-1:0]          rd_busy
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] r_regs [DEPTH];
   logic [DEPTH-1:0]  r_busy;
   logic [DEPTH-1:0]  w_busy_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
         r_busy <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (!(ZERO_REG != 0 && i == 0)) begin
               // The load port wins a same-index collision.
               if (wb1_en && wb1_idx == ADDR_W'(i))
                  r_regs[i] <= wb1_data;
               else if (wb0_en && wb0_idx == ADDR_W'(i))
                  r_regs[i] <= wb0_data;
            end
         end
         r_busy <= w_busy_nxt;
      end
   end

   // Set is applied after the write-back clears so a new producer keeps the register busy.
   always_comb begin
      w_busy_nxt = r_busy;
      if (sb_flush) begin
         w_busy_nxt = '0;
      end else begin
         if (wb0_en)    w_busy_nxt[wb0_idx]    = 1'b0;
         if (wb1_en)    w_busy_nxt[wb1_idx]    = 1'b0;
         if (sb_set_en) w_busy_nxt[sb_set_idx] = 1'b1;
         if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] w_idx;
      logic              w_zero;
      logic              w_hit0;
      logic              w_hit1;

      assign w_idx  = rd_idx[k*ADDR_W +: ADDR_W];
      assign w_zero = (ZERO_REG != 0) && (w_idx == '0);
      assign w_hit1 = wb1_en && (wb1_idx == w_idx);
      assign w_hit0 = wb0_en && (wb0_idx == w_idx);

      // Reset forces quiet outputs immediately, even while a write-back is presented.
      assign rd_data[k*DATA_W +: DATA_W] = (!rst || w_zero) ? '0       :
                                           w_hit1           ? wb1_data :
                                           w_hit0           ? wb0_data :
                                                              r_regs[w_idx];
      assign rd_busy[k] = rst && !w_zero && r_busy[w_idx] && !(w_hit0 || w_hit1);
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed vector table on the default configuration, plus
// reset/x0 sequences and a randomised model check on a 3-port 64-bit instance.
module tb_regfile_mp;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Instance A: defaults (32-bit, 2 ports, x0 hardwired)
   logic        a_wb0_en, a_wb1_en, a_set_en, a_flush;
   logic [4:0]  a_wb0_idx, a_wb1_idx, a_set_idx;
   logic [31:0] a_wb0_data, a_wb1_data;
   logic [9:0]  a_rd_idx;
   logic [63:0] a_rd_data;
   logic [1:0]  a_rd_busy;

   regfile_mp u_a (
      .clk(clk), .rst(rst),
      .wb0_en(a_wb0_en), .wb0_idx(a_wb0_idx), .wb0_data(a_wb0_data),
      .wb1_en(a_wb1_en), .wb1_idx(a_wb1_idx), .wb1_data(a_wb1_data),
      .sb_set_en(a_set_en), .sb_set_idx(a_set_idx), .sb_flush(a_flush),
      .rd_idx(a_rd_idx), .rd_data(a_rd_data), .rd_busy(a_rd_busy)
   );

   // Instance B: 64-bit, 3 ports, x0 ordinary
   logic         b_wb0_en, b_wb1_en, b_set_en, b_flush;
   logic [4:0]   b_wb0_idx, b_wb1_idx, b_set_idx;
   logic [63:0]  b_wb0_data, b_wb1_data;
   logic [14:0]  b_rd_idx;
   logic [191:0] b_rd_data;
   logic [2:0]   b_rd_busy;

   regfile_mp #(.DATA_W(64), .ADDR_W(5), .NUM_RD(3), .ZERO_REG(0)) u_b (
      .clk(clk), .rst(rst),
      .wb0_en(b_wb0_en), .wb0_idx(b_wb0_idx), .wb0_data(b_wb0_data),
      .wb1_en(b_wb1_en), .wb1_idx(b_wb1_idx), .wb1_data(b_wb1_data),
      .sb_set_en(b_set_en), .sb_set_idx(b_set_idx), .sb_flush(b_flush),
      .rd_idx(b_rd_idx), .rd_data(b_rd_data), .rd_busy(b_rd_busy)
   );

   typedef struct {
      logic        w0e;
      logic [4:0]  w0i;
      logic [31:0] w0d;
      logic        w1e;
      logic [4:0]  w1i;
      logic [31:0] w1d;
      logic        se;
      logic [4:0]  si;
      logic        fl;
      logic [4:0]  r0;
      logic [4:0]  r1;
      logic [31:0] d0;
      logic        b0;
      logic [31:0] d1;
      logic        b1;
   } vec_t;

   vec_t vecs [19];

   function automatic vec_t mk(
      input logic w0e, input logic [4:0] w0i, input logic [31:0] w0d,
      input logic w1e, input logic [4:0] w1i, input logic [31:0] w1d,
      input logic se,  input logic [4:0] si,  input logic fl,
      input logic [4:0] r0, input logic [4:0] r1,
      input logic [31:0] d0, input logic b0, input logic [31:0] d1, input logic b1);
      vec_t v;
      v.w0e = w0e; v.w0i = w0i; v.w0d = w0d;
      v.w1e = w1e; v.w1i = w1i; v.w1d = w1d;
      v.se = se; v.si = si; v.fl = fl;
      v.r0 = r0; v.r1 = r1;
      v.d0 = d0; v.b0 = b0; v.d1 = d1; v.b1 = b1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic a_idle();
      a_wb0_en = 0; a_wb0_idx = 0; a_wb0_data = 0;
      a_wb1_en = 0; a_wb1_idx = 0; a_wb1_data = 0;
      a_set_en = 0; a_set_idx = 0; a_flush = 0;
   endtask

   task automatic b_idle();
      b_wb0_en = 0; b_wb0_idx = 0; b_wb0_data = 0;
      b_wb1_en = 0; b_wb1_idx = 0; b_wb1_data = 0;
      b_set_en = 0; b_set_idx = 0; b_flush = 0;
   endtask

   logic [63:0]  m_mem [32];
   logic [31:0]  m_busy;
   logic [191:0] e_data;
   logic [2:0]   e_busy;

   initial begin
      a_idle(); b_idle();
      a_rd_idx = 0; b_rd_idx = 0;

      // Expected values derived by hand, one row per cycle, in order.
      //            w0e w0i  w0d            w1e w1i  w1d            se  si    fl  r0    r1    d0             b0  d1             b1
      vecs[0]  = mk(0, 5'd0, 32'h0,          0, 5'd0, 32'h0,          0, 5'd0, 0, 5'd5, 5'd7, 32'h0,          0, 32'h0,          0);
      vecs[1]  = mk(1, 5'd5, 32'hDEADBEEF,   0, 5'd0, 32'h0,          0, 5'd0, 0, 5'd5, 5'd5, 32'hDEADBEEF,   0, 32'hDEADBEEF,   0);
      vecs[2]  = mk(0, 5'd0, 32'h0,          0, 5'd0, 32'h0,          0, 5'd0, 0, 5'd5, 5'd0, 32'hDEADBEEF,   0, 32'h0,          0);
      vecs[3]  = mk(1, 5'd7, 32'h11,         1, 5'd7, 32'h22,         0, 5'd0, 0, 5'd7, 5'd5, 32'h22,         0, 32'hDEADBEEF,   0);
      vecs[4]  = mk(0, 5'd0, 32'h0,          0, 5'd0, 32'h0,          0, 5'd0, 0, 5'd7, 5'd7, 32'h22,         0, 32'h22,         0);
      vecs[5]  = mk(0, 5'd0, 32'h0,          1, 5'd0, 32'hFFFFFFFF,   1, 5'd0, 0, 5'd0, 5'd0, 32'h0,          0, 32'h0,          0);
      vecs[6]  = mk(0, 5'd0, 32'h0,          0, 5'd0, 32'h0,          0, 5'd0, 0, 5'd0, 5'd0, 32'h0,          0, 32'h0,          0);
      vecs[7]  = mk(0, 5'd0, 32'h0,          0, 5'd0, 32'h0,          1, 5'd3, 0, 5'd3, 5'd3, 32'h0,          0, 32'h0,          0);
      vecs[8]  = mk(0, 5'd0, 32'h0,          0, 5'd0, 32'h0,          0, 5'd0, 0, 5'd3, 5'd5, 32'h0,          1, 32'hDEADBEEF,   0);
      vecs[9]  = mk(1, 5'd3, 32'h33,         0, 5'd0, 32'h0,          0, 5'd0, 0, 5'd3, 5'd3, 32'h33,         0, 32'h33,         0);
      vecs[10] = mk(0, 5'd0, 32'h0,          0, 5'd0, 32'h0,          0, 5'd0, 0, 5'd3, 5'd3, 32'h33,         0, 32'h33,         0);
      vecs[11] = mk(1, 5'd3, 32'h44,         0, 5'd0, 32'h0,          1, 5'd3, 0, 5'd3, 5'd3, 32'h44,         0, 32'h44,         0);
      vecs[12] = mk(0, 5'd0, 32'h0,          0, 5'd0, 32'h0,          0, 5'd0, 0, 5'd3, 5'd3, 32'h44,         1, 32'h44,         1);
      vecs[13] = mk(0, 5'd0, 32'h0,          0, 5'd0, 32'h0,          1, 5'd9, 0, 5'd9, 5'd3, 32'h0,          0, 32'h44,         1);
      vecs[14] = mk(0, 5'd0, 32'h0,          0, 5'd0, 32'h0,          1, 5'd10,1, 5'd9, 5'd3, 32'h0,          1, 32'h44,         1);
      vecs[15] = mk(0, 5'd0, 32'h0,          0, 5'd0, 32'h0,          0, 5'd0, 0, 5'd9, 5'd10,32'h0,          0, 32'h0,          0);
      vecs[16] = mk(1, 5'd10,32'hAA,         1, 5'd9, 32'h99,         0, 5'd0, 0, 5'd9, 5'd10,32'h99,         0, 32'hAA,         0);
      vecs[17] = mk(1, 5'd12,32'h55,         1, 5'd12,32'h12,         1, 5'd12,0, 5'd12,5'd10,32'h12,         0, 32'hAA,         0);
      vecs[18] = mk(0, 5'd0, 32'h0,          0, 5'd0, 32'h0,          0, 5'd0, 0, 5'd12,5'd9, 32'h12,         1, 32'h99,         0);

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         a_wb0_en = vecs[i].w0e; a_wb0_idx = vecs[i].w0i; a_wb0_data = vecs[i].w0d;
         a_wb1_en = vecs[i].w1e; a_wb1_idx = vecs[i].w1i; a_wb1_data = vecs[i].w1d;
         a_set_en = vecs[i].se;  a_set_idx = vecs[i].si;  a_flush = vecs[i].fl;
         a_rd_idx = {vecs[i].r1, vecs[i].r0};
         #2;
         chk($sformatf("v%0d_data0", i), 192'(a_rd_data[31:0]),  192'(vecs[i].d0));
         chk($sformatf("v%0d_data1", i), 192'(a_rd_data[63:32]), 192'(vecs[i].d1));
         chk($sformatf("v%0d_busy0", i), 192'(a_rd_busy[0]),     192'(vecs[i].b0));
         chk($sformatf("v%0d_busy1", i), 192'(a_rd_busy[1]),     192'(vecs[i].b1));
      end

      // Asynchronous reset mid-cycle while a bypassing write is presented.
      @(negedge clk);
      a_idle();
      a_wb0_en = 1; a_wb0_idx = 5'd9; a_wb0_data = 32'hAB;
      a_rd_idx = {5'd9, 5'd12};
      #1;
      chk("pre_rst_data", 192'(a_rd_data), 192'({32'hAB, 32'h12}));
      chk("pre_rst_busy", 192'(a_rd_busy), 192'(2'b01));
      rst = 1'b0;
      #1;
      chk("in_rst_data", 192'(a_rd_data), 192'(0));
      chk("in_rst_busy", 192'(a_rd_busy), 192'(0));
      @(negedge clk);
      a_idle();
      rst = 1'b1;
      a_rd_idx = {5'd7, 5'd12};
      #1;
      chk("post_rst_data", 192'(a_rd_data), 192'(0));
      chk("post_rst_busy", 192'(a_rd_busy), 192'(0));

      // x0 as an ordinary register on instance B.
      @(negedge clk);
      b_wb1_en = 1; b_wb1_idx = 0; b_wb1_data = 64'hFFFFFFFF;
      b_set_en = 1; b_set_idx = 0;
      b_rd_idx = {5'd0, 5'd0, 5'd0};
      #2;
      chk("b_x0_bypass", b_rd_data, {3{64'hFFFFFFFF}});
      chk("b_x0_bypass_busy", 192'(b_rd_busy), 192'(0));
      @(negedge clk);
      b_idle();
      #2;
      chk("b_x0_data", b_rd_data, {3{64'hFFFFFFFF}});
      chk("b_x0_busy", 192'(b_rd_busy), 192'(3'b111));

      for (int r = 0; r < 32; r++) m_mem[r] = '0;
      m_mem[0] = 64'hFFFFFFFF;
      m_busy = 32'h1;

      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         b_wb0_en   = 1'($urandom_range(0, 1));
         b_wb0_idx  = 5'($urandom_range(0, 7));
         b_wb0_data = {$urandom, $urandom};
         b_wb1_en   = 1'($urandom_range(0, 1));
         b_wb1_idx  = 5'($urandom_range(0, 7));
         b_wb1_data = {$urandom, $urandom};
         b_set_en   = 1'($urandom_range(0, 1));
         b_set_idx  = 5'($urandom_range(0, 7));
         b_flush    = ($urandom_range(0, 15) == 0);
         b_rd_idx   = {5'($urandom_range(0, 8)), 5'($urandom_range(0, 8)), 5'($urandom_range(0, 8))};
         for (int k = 0; k < 3; k++) begin
            logic [4:0] ix;
            ix = b_rd_idx[k*5 +: 5];
            if (b_wb1_en && b_wb1_idx == ix)      e_data[k*64 +: 64] = b_wb1_data;
            else if (b_wb0_en && b_wb0_idx == ix) e_data[k*64 +: 64] = b_wb0_data;
            else                                  e_data[k*64 +: 64] = m_mem[ix];
            e_busy[k] = m_busy[ix] && !((b_wb0_en && b_wb0_idx == ix) || (b_wb1_en && b_wb1_idx == ix));
         end
         #2;
         chk($sformatf("rnd%0d_data", c), b_rd_data, e_data);
         chk($sformatf("rnd%0d_busy", c), 192'(b_rd_busy), 192'(e_busy));
         if (b_wb0_en) m_mem[b_wb0_idx] = b_wb0_data;
         if (b_wb1_en) m_mem[b_wb1_idx] = b_wb1_data;
         if (b_flush) begin
            m_busy = '0;
         end else begin
            if (b_wb0_en) m_busy[b_wb0_idx] = 1'b0;
            if (b_wb1_en) m_busy[b_wb1_idx] = 1'b0;
            if (b_set_en) m_busy[b_set_idx] = 1'b1;
         end
      end

      @(negedge clk);
      b_idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
